counter_updn_mod: RTL and testbench
===================================

// Module: counter_updn_mod
// PURPOSE
//   Parametrised synchronous up/down modulo-N counter, successor to the fixed 4-bit
//   binary up-counter. Adds width and modulus parameters, up/down direction, a
//   synchronous load and clear, a direction-aware terminal count, and a registered
//   wrap pulse. Stages cascade through CET/TC in the same way as the 4-bit part.
// PARAMETERS
//   WIDTH    4   counter width in bits (1..32)
//   MODULUS  16  count range is 0..MODULUS-1; legal range 2..2**WIDTH
// PORTS
//   CP    in   1      clock, rising edge
//   CR    in   1      asynchronous clear, active-low; Q<=0, WRAP<=0
//   SR    in   1      synchronous clear, active-low
//   PE    in   1      synchronous parallel load, active-low
//   CEP   in   1      count enable (parallel)
//   CET   in   1      count enable (trickle); also gates TC
//   UD    in   1      direction: 1 = up, 0 = down
//   D     in   WIDTH  load data
//   Q     out  WIDTH  count value
//   TC    out  1      terminal count, combinational
//   WRAP  out  1      registered one-cycle pulse, asserted the cycle after a wrap
// BEHAVIOUR
//   - Reset: CR=0 forces Q=0 and WRAP=0 immediately, independent of CP. CR has
//     priority over everything and holds while low. First count edge is the first
//     rising CP with CR=1.
//   - Per rising CP, when CR=1, the first matching row applies:
//       1. SR=0              -> Q<=0
//       2. PE=0              -> Q<=D, or Q<=MODULUS-1 if D>=MODULUS (clamp)
//       3. CEP=1 & CET=1     -> count:
//            UD=1: Q<=(Q==MODULUS-1) ? 0 : Q+1
//            UD=0: Q<=(Q==0) ? MODULUS-1 : Q-1
//       4. otherwise         -> Q holds
//   - TC = CET & (UD ? (Q==MODULUS-1) : (Q==0)).
//     TC ignores CEP, SR and PE, which matches 74-series cascade semantics.
//   - WRAP<=1 only on an edge where row 3 applied and Q was at the terminal value
//     for the current UD. WRAP<=0 on every other edge, including clear and load.
//   - UD may change on any cycle. The new direction takes effect at the next edge.
//     TC follows UD combinationally.
//   - MODULUS==2**WIDTH: natural binary wrap, with no extra compare on the wrap path.
//   - Counter arithmetic is WIDTH bits wide. Q never leaves 0..MODULUS-1 after
//     reset, because loads are clamped.
//   - Latency: Q updates one edge after the control inputs are sampled.
//     TC is valid in the same cycle as Q.
//   - No internal clock gating. Every sequential element is clocked by CP and
//     cleared by CR.
// TESTING
//   1. WIDTH=4, MODULUS=10, UD=1, CEP=CET=1, 12 edges from reset
//      -> Q=1..9,0,1,2; TC=1 only while Q=9; WRAP=1 for exactly the cycle after Q=9->0.
//   2. Same config, UD=0 from Q=0
//      -> Q=9,8,...; TC=1 while Q=0; WRAP pulses after 0->9.
//   3. PE=0, D=4'hC (>=10)
//      -> Q=9 next edge. PE=0 with SR=0 -> Q=0 (SR wins).
//      PE=0 with CEP=CET=1 -> load wins, no count.
//   4. CET=0 at Q=9 with CEP=1
//      -> Q holds, TC=0, WRAP=0. CEP=0, CET=1 at Q=9 -> Q holds, TC=1.
//   5. Drop CR between edges mid-count (Q=6)
//      -> Q=0, WRAP=0 immediately. Release CR -> counting resumes from 0 on the next edge.
//   6. Two instances, WIDTH=4, MODULUS=16; TC of the low stage drives CET/CEP of the
//      high stage; 300 up edges -> {Qhi,Qlo}=300 mod 256=44.

Source files
------------

// File: rtl/counter_updn_mod.sv
// Up/down modulo-N counter with sync clear/load, cascadable TC and registered wrap pulse.
// Latency: Q and WRAP one CP edge after sampling; TC combinational; no backpressure (CET gates cascade).
module counter_updn_mod #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             SR,
  input  logic             PE,
  input  logic             CEP,
  input  logic             CET,
  input  logic             UD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);
  localparam bit               FULL = (MODULUS == (64'd1 << WIDTH));

  logic             at_top;
  logic             at_bot;
  logic             cnt_en;
  logic             hit_term;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt_val;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  assign at_top   = (Q == MAXV);
  assign at_bot   = (Q == '0);
  assign cnt_en   = CEP & CET;
  assign hit_term = UD ? at_top : at_bot;
  assign TC       = CET & hit_term;

  // A full-range modulus never clamps and wraps naturally in WIDTH-bit arithmetic.
  assign load_val = (!FULL && (D > MAXV)) ? MAXV : D;

  always_comb begin
    cnt_val = Q;
    if (UD) begin
      if (!FULL && at_top) cnt_val = '0;
      else                 cnt_val = Q + WIDTH'(1);
    end else begin
      if (!FULL && at_bot) cnt_val = MAXV;
      else                 cnt_val = Q - WIDTH'(1);
    end
  end

  always_comb begin
    q_nxt    = Q;
    wrap_nxt = 1'b0;
    if (!SR) begin
      q_nxt = '0;
    end else if (!PE) begin
      q_nxt = load_val;
    end else if (cnt_en) begin
      q_nxt    = cnt_val;
      wrap_nxt = hit_term;
    end
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      Q    <= '0;
      WRAP <= 1'b0;
    end else begin
      Q    <= q_nxt;
      WRAP <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_counter_updn_mod.sv
// Bench for counter_updn_mod: directed and random stimulus against an arithmetic modulo model,
// plus a two-stage MODULUS=16 cascade.
module tb_counter_updn_mod;

  localparam int M = 10;

  logic       cp = 1'b0;
  logic       cr, sr, pe, cep, cet, ud;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc, wrap;

  logic       c_cr;
  logic [3:0] q_lo, q_hi;
  logic       tc_lo, tc_hi, wrap_lo, wrap_hi;

  int n_vec  = 0;
  int n_err  = 0;
  int mq     = 0;
  int mwrap  = 0;
  int casc_n = 0;

  always #5 cp = ~cp;

  counter_updn_mod #(.WIDTH(4), .MODULUS(10)) dut (
    .CP(cp), .CR(cr), .SR(sr), .PE(pe), .CEP(cep), .CET(cet), .UD(ud),
    .D(d), .Q(q), .TC(tc), .WRAP(wrap)
  );

  counter_updn_mod #(.WIDTH(4), .MODULUS(16)) u_lo (
    .CP(cp), .CR(c_cr), .SR(1'b1), .PE(1'b1), .CEP(1'b1), .CET(1'b1), .UD(1'b1),
    .D(4'd0), .Q(q_lo), .TC(tc_lo), .WRAP(wrap_lo)
  );

  counter_updn_mod #(.WIDTH(4), .MODULUS(16)) u_hi (
    .CP(cp), .CR(c_cr), .SR(1'b1), .PE(1'b1), .CEP(tc_lo), .CET(tc_lo), .UD(1'b1),
    .D(4'd0), .Q(q_hi), .TC(tc_hi), .WRAP(wrap_hi)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_tc();
    if (!cet) return 0;
    return ud ? int'(mq == M - 1) : int'(mq == 0);
  endfunction

  // Drive one cycle of controls, check TC before the edge, advance the model, check after.
  task automatic step(input logic s_sr, input logic s_pe, input logic s_cep,
                      input logic s_cet, input logic s_ud, input logic [3:0] s_d);
    sr = s_sr; pe = s_pe; cep = s_cep; cet = s_cet; ud = s_ud; d = s_d;
    #1;
    chk("tc_pre", 32'(tc), 32'(model_tc()));
    @(posedge cp);
    mwrap = 0;
    if (!sr) begin
      mq = 0;
    end else if (!pe) begin
      mq = (int'(d) >= M) ? M - 1 : int'(d);
    end else if (cep && cet) begin
      mwrap = ud ? int'(mq == M - 1) : int'(mq == 0);
      mq    = ud ? (mq + 1) % M : (mq + M - 1) % M;
    end
    #1;
    chk("q", 32'(q), 32'(mq));
    chk("wrap", 32'(wrap), 32'(mwrap));
    chk("tc_post", 32'(tc), 32'(model_tc()));
  endtask

  task automatic async_clear();
    #2 cr = 1'b0;
    #1;
    chk("clr_q", 32'(q), 32'd0);
    chk("clr_wrap", 32'(wrap), 32'd0);
    mq = 0; mwrap = 0;
    #1 cr = 1'b1;
  endtask

  initial begin
    cr = 1'b0; sr = 1'b1; pe = 1'b1; cep = 1'b1; cet = 1'b1; ud = 1'b1; d = 4'd0;
    c_cr = 1'b0;
    #2;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    @(posedge cp); #1;
    chk("rst_hold_q", 32'(q), 32'd0);
    #4 cr = 1'b1;

    // Count up 12 edges: 1..9,0,1,2.
    for (int i = 0; i < 12; i++) step(1, 1, 1, 1, 1, 4'd0);
    chk("up12_q", 32'(q), 32'd2);

    // Clear, then count down through the 0->9 wrap.
    step(0, 1, 1, 1, 1, 4'd0);
    for (int i = 0; i < 12; i++) step(1, 1, 1, 1, 0, 4'd0);

    // Load clamp, clear beats load, load beats count.
    step(1, 0, 0, 0, 1, 4'hC);
    chk("clamp_q", 32'(q), 32'd9);
    step(0, 0, 0, 0, 1, 4'h5);
    chk("sr_wins_q", 32'(q), 32'd0);
    step(1, 0, 1, 1, 1, 4'h5);
    chk("load_wins_q", 32'(q), 32'd5);

    // Trickle/parallel enables at the terminal value.
    step(1, 0, 0, 0, 1, 4'h9);
    step(1, 1, 1, 0, 1, 4'h0);
    chk("cet0_q", 32'(q), 32'd9);
    chk("cet0_tc", 32'(tc), 32'd0);
    step(1, 1, 0, 1, 1, 4'h0);
    chk("cep0_q", 32'(q), 32'd9);
    chk("cep0_tc", 32'(tc), 32'd1);

    // Async clear mid-count at Q=6, then resume from 0.
    step(0, 1, 1, 1, 1, 4'd0);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 1, 1, 4'd0);
    chk("pre_clr_q", 32'(q), 32'd6);
    async_clear();
    step(1, 1, 1, 1, 1, 4'd0);
    chk("resume_q", 32'(q), 32'd1);

    // Random traffic with occasional async clears.
    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 9) != 0),
           logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 49) == 0) async_clear();
    end

    // Cascade: 300 up edges on the low stage.
    chk("casc_rst", 32'({q_hi, q_lo}), 32'd0);
    #4 c_cr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge cp); #1;
      casc_n++;
      chk("casc", 32'({q_hi, q_lo}), 32'(casc_n % 256));
    end
    chk("casc300", 32'({q_hi, q_lo}), 32'd44);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
